while_loop_sequencer: RTL and testbench

// - Sequential controller for the bounded while-loop datapath XOUT = (temp*A) - B, where temp = INIT + COUNT.
// - Runs one loop increment per clock instead of unrolling combinationally.
// - Accepts operand pairs over a valid/ready handshake and returns results over a valid/ready handshake.
// - Sits between an operand producer and a result consumer; handles one job at a time.

---
 rtl/while_loop_sequencer_if.sv | 28 ++
 rtl/while_loop_sequencer.sv | 108 ++++++++++
 tb/tb_while_loop_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/while_loop_sequencer_if.sv
// Operand/result handshake bundle for while_loop_sequencer.
// master = producer/consumer side, slave = sequencer side.
interface while_loop_sequencer_if #(
    parameter int NBITS = 8,
    parameter int COUNT = 4
);
    localparam int IW = ($clog2(COUNT + 1) > 1) ? $clog2(COUNT + 1) : 1;

    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] xout;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [IW-1:0]    iter;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, xout, out_valid, busy, iter
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, xout, out_valid, busy, iter
    );
endinterface

// File: rtl/while_loop_sequencer.sv
// Sequential evaluation of xout = ((init+count)*a) - b, one loop increment per clock.
// Optional macro WHILE_SEQ_EARLY_EXIT_EN: a==0 skips the loop and goes straight to CALC.
module while_loop_sequencer #(
    parameter int NBITS = 8,
    parameter int COUNT = 4,
    parameter int INIT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    while_loop_sequencer_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam int IW = ($clog2(COUNT + 1) > 1) ? $clog2(COUNT + 1) : 1;
    localparam logic [NBITS-1:0] INIT_T = NBITS'(INIT);
    localparam logic [NBITS-1:0] ONE_N  = NBITS'(1);
    localparam logic [IW-1:0]    ONE_I  = IW'(1);
    localparam logic [IW-1:0]    LAST   = IW'((COUNT > 0) ? COUNT - 1 : 0);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high. in_ready depends on state only; xout/out_valid hold until out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] temp_q, temp_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic [NBITS-1:0] xout_q, xout_d;
    logic             ov_q, ov_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic [NBITS-1:0] prod;

    // Product is kept at NBITS so the subtract wraps on the truncated value.
    assign prod = temp_q * a_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            temp_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            xout_q  <= '0;
            ov_q    <= 1'b0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            a_q     <= a_d;
            b_q     <= b_d;
            xout_q  <= xout_d;
            ov_q    <= ov_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        a_d     = a_q;
        b_d     = b_q;
        xout_d  = xout_q;
        ov_d    = ov_q;
        iter_d  = iter_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d    = bus.a;
                    b_d    = bus.b;
                    temp_d = INIT_T;
                    iter_d = '0;
                    if (COUNT == 0) state_d = CALC;
                    else            state_d = LOOP;
`ifdef WHILE_SEQ_EARLY_EXIT_EN
                    if (bus.a == '0) state_d = CALC;
`endif
                end
            end
            LOOP: begin
                temp_d = temp_q + ONE_N;
                iter_d = iter_q + ONE_I;
                if (iter_q == LAST) state_d = CALC;
            end
            CALC: begin
                xout_d  = prod - b_q;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.xout      = xout_q;
    assign bus.out_valid = ov_q;
    assign bus.iter      = iter_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_while_loop_sequencer.sv
// Self-checking bench for while_loop_sequencer: directed vectors, back-pressure,
// mid-job reset and randomized jobs against an arithmetic reference model.
module tb_while_loop_sequencer;
    localparam int NBITS = 8;
    localparam int COUNT = 4;
    localparam int INIT  = 1;
    localparam int TMO   = 50;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         errors;
    int         checks;
    logic [NBITS-1:0] exp_q[$];

    while_loop_sequencer_if #(.NBITS(NBITS), .COUNT(COUNT)) bus ();

    while_loop_sequencer #(.NBITS(NBITS), .COUNT(COUNT), .INIT(INIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain modular arithmetic on the job definition.
    function automatic logic [NBITS-1:0] model_x(input int av, input int bv);
        int r;
        r = ((INIT + COUNT) * av - bv) % 256;
        if (r < 0) r += 256;
        return r[NBITS-1:0];
    endfunction

    function automatic int model_lat(input int av);
`ifdef WHILE_SEQ_EARLY_EXIT_EN
        if (av == 0) return 1;
`endif
        return COUNT + 1;
    endfunction

    function automatic int model_iter(input int av);
`ifdef WHILE_SEQ_EARLY_EXIT_EN
        if (av == 0) return 0;
`endif
        return COUNT;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Driver: submit one job, check latency/result, hold off out_ready for 'hold' cycles.
    task automatic run_job(input logic [NBITS-1:0] av, input logic [NBITS-1:0] bv, input int hold);
        int lat;
        logic [NBITS-1:0] exp_x;
        logic [NBITS-1:0] x0;
        exp_q.push_back(model_x(int'(av), int'(bv)));
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_before_accept: got %b want 1", bus.in_ready);
        end
        cyc();
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin
            cyc();
            lat++;
        end
        checks++;
        if (lat >= TMO) begin
            errors++; $display("FAIL out_valid_timeout: no out_valid within %0d cycles", TMO);
            void'(exp_q.pop_front());
            return;
        end
        checks++;
        if (lat != model_lat(int'(av))) begin
            errors++; $display("FAIL latency a=%0d: got %0d want %0d", av, lat, model_lat(int'(av)));
        end
        exp_x = exp_q.pop_front();
        checks++;
        if (bus.xout !== exp_x) begin
            errors++; $display("FAIL xout a=%0d b=%0d: got %0d want %0d", av, bv, bus.xout, exp_x);
        end
        checks++;
        if (int'(bus.iter) != model_iter(int'(av))) begin
            errors++; $display("FAIL iter a=%0d: got %0d want %0d", av, bus.iter, model_iter(int'(av)));
        end
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL done_flags: in_ready=%b busy=%b want 0/1", bus.in_ready, bus.busy);
        end
        x0 = bus.xout;
        for (int i = 0; i < hold; i++) begin
            cyc();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.xout !== x0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stable: ov=%b xout=%0d in_ready=%b busy=%b want 1/%0d/0/1",
                         bus.out_valid, bus.xout, bus.in_ready, bus.busy, x0);
            end
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL after_handshake: ov=%b in_ready=%b busy=%b want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        cyc(); cyc();
        checks++;
        if (bus.xout !== '0 || bus.out_valid !== 1'b0 || bus.iter !== '0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: xout=%0d ov=%b iter=%0d in_ready=%b busy=%b st=%0d want 0/0/0/1/0/0",
                     bus.xout, bus.out_valid, bus.iter, bus.in_ready, bus.busy, dbg_state);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_directed();
        run_job(8'd3,   8'd2,  0);
        run_job(8'd100, 8'd0,  0);
        run_job(8'd1,   8'd10, 1);
        run_job(8'd0,   8'd7,  0);
    endtask

    task automatic test_backpressure();
        run_job(8'd5, 8'd9, 3);
    endtask

    // New job presented during DONE must wait until the cycle after out_ready.
    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        bus.a = 8'd7; bus.b = 8'd3; bus.in_valid = 1'b1;
        cyc();
        bus.a = 8'd9; bus.b = 8'd1;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_no_accept_busy: in_ready=%b want 0", bus.in_ready);
            end
            cyc();
            lat++;
        end
        checks++;
        if (bus.xout !== model_x(7, 3)) begin
            errors++; $display("FAIL b2b_first_xout: got %0d want %0d", bus.xout, model_x(7, 3));
        end
        cyc();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_done_hold: in_ready=%b ov=%b want 0/1", bus.in_ready, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_gap: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
        end
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL b2b_second_accept: busy=%b want 1", bus.busy);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < TMO) begin
            cyc();
            lat++;
        end
        checks++;
        if (bus.xout !== model_x(9, 1) || lat != model_lat(9)) begin
            errors++;
            $display("FAIL b2b_second_job: xout=%0d lat=%0d want %0d/%0d", bus.xout, lat, model_x(9, 1), model_lat(9));
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.a = 8'd11; bus.b = 8'd4; bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        cyc(); cyc();
        checks++;
        if (int'(bus.iter) != 2 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_iter: iter=%0d busy=%b want 2/1", bus.iter, bus.busy);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.iter !== '0 || bus.xout !== '0 ||
            bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: ov=%b iter=%0d xout=%0d in_ready=%b busy=%b want 0/0/0/1/0",
                     bus.out_valid, bus.iter, bus.xout, bus.in_ready, bus.busy);
        end
        for (int i = 0; i < COUNT + 3; i++) begin
            cyc();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++; $display("FAIL aborted_job_output: ov=%b busy=%b want 0/0", bus.out_valid, bus.busy);
            end
        end
    endtask

    task automatic test_random();
        logic [NBITS-1:0] av, bv;
        for (int n = 0; n < 20; n++) begin
            av = NBITS'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) av = '0;
            bv = NBITS'($urandom_range(0, 255));
            run_job(av, bv, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.a = '0; bus.b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d results outstanding, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
